// File: rtl/vga_fb_fetch_if.sv
// SRAM read port between the framebuffer fetcher (master) and the SRAM arbiter (slave).
interface vga_fb_fetch_if #(
    parameter int ADDR_W = 9
);
    logic              data_en;
    logic [ADDR_W-1:0] word_address_dest;
    logic [3:0]        byte_select;
    logic              SRAM_busy;
    logic [31:0]       SRAM_data_in;

    modport master (
        output data_en, word_address_dest, byte_select,
        input  SRAM_busy, SRAM_data_in
    );

    modport slave (
        input  data_en, word_address_dest, byte_select,
        output SRAM_busy, SRAM_data_in
    );
endinterface

// File: rtl/vga_fb_fetch.sv
// Prefetches one 1 bpp framebuffer row into a ping-pong line buffer and serves pixels from the front half.
// Row fetch takes WORDS_PER_ROW accepts + 1 cycle; SRAM_busy stalls the request in place; pixel read is 1 cycle.
module vga_fb_fetch #(
    parameter int WORDS_PER_ROW = 4,
    parameter int ROWS          = 96,
    parameter int ADDR_W        = 9,
    parameter int BASE_ADDR     = 0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                fetch_start,
    input  logic [6:0]          fetch_row,
    input  logic                buf_swap,
    input  logic                underrun_clr,
    vga_fb_fetch_if.master      sram,
    input  logic [6:0]          pix_x,
    output logic                pixel_data,
    output logic                fetch_busy,
    output logic                fetch_done,
    output logic                underrun
);
    localparam int IDX_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {IDLE, REQ, ZERO, DONE} state_t;

    state_t           state, state_nxt;
    logic [6:0]       row;
    logic [IDX_W-1:0] word_idx;
    logic             front_sel;
    logic [31:0]      fb [2][WORDS_PER_ROW];
    logic             data_en;
    logic             accept;
    logic             last_accept;
    logic             swap_ok;
    logic             swap_bad;

    assign accept      = (state == REQ) && !sram.SRAM_busy;
    assign last_accept = accept && (word_idx == LAST_IDX);

    // A swap coinciding with the final word is safe: that word lands in the half that becomes front.
    assign swap_ok  = (state == IDLE) || (state == DONE) || last_accept;
    assign swap_bad = buf_swap && !swap_ok;

    assign sram.data_en           = data_en;
    assign sram.byte_select       = data_en ? 4'b1111 : 4'b0000;
    assign sram.word_address_dest = data_en ? (ADDR_W'(BASE_ADDR)
                                               + ADDR_W'(row) * ADDR_W'(WORDS_PER_ROW)
                                               + ADDR_W'(word_idx))
                                            : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        data_en    = 1'b0;
        fetch_busy = 1'b0;
        fetch_done = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_start)
                    state_nxt = (32'(fetch_row) < ROWS) ? REQ : ZERO;
            end
            REQ: begin
                data_en    = 1'b1;
                fetch_busy = 1'b1;
                if (last_accept) state_nxt = DONE;
            end
            ZERO: begin
                fetch_busy = 1'b1;
                state_nxt  = DONE;
            end
            DONE: begin
                fetch_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row        <= '0;
            word_idx   <= '0;
            front_sel  <= 1'b0;
            underrun   <= 1'b0;
            pixel_data <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < WORDS_PER_ROW; w++)
                    fb[b][w] <= '0;
        end else begin
            if ((state == IDLE) && fetch_start) begin
                row      <= fetch_row;
                word_idx <= '0;
            end
            if (accept) begin
                fb[~front_sel][word_idx] <= sram.SRAM_data_in;
                if (word_idx != LAST_IDX) word_idx <= word_idx + 1'b1;
            end
            if (state == ZERO)
                for (int w = 0; w < WORDS_PER_ROW; w++)
                    fb[~front_sel][w] <= '0;
            if (buf_swap && swap_ok) front_sel <= ~front_sel;
            if (swap_bad)          underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
            // Bit 0 of each word is the leftmost pixel.
            pixel_data <= fb[front_sel][pix_x[6:5]][pix_x[4:0]];
        end
    end
endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench for vga_fb_fetch with a behavioural SRAM and per-vector expected values.
module tb_vga_fb_fetch;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       fetch_start = 1'b0;
    logic [6:0] fetch_row = '0;
    logic       buf_swap = 1'b0;
    logic       underrun_clr = 1'b0;
    logic [6:0] pix_x = '0;
    logic       pixel_data, fetch_busy, fetch_done, underrun;
    logic [31:0] mem [512];
    int n_vec = 0;
    int n_bad = 0;

    vga_fb_fetch_if #(.ADDR_W(9)) sif ();

    vga_fb_fetch #(.WORDS_PER_ROW(4), .ROWS(96), .ADDR_W(9), .BASE_ADDR(0)) dut (
        .clk(clk), .nrst(nrst), .fetch_start(fetch_start), .fetch_row(fetch_row),
        .buf_swap(buf_swap), .underrun_clr(underrun_clr), .sram(sif.master),
        .pix_x(pix_x), .pixel_data(pixel_data), .fetch_busy(fetch_busy),
        .fetch_done(fetch_done), .underrun(underrun)
    );

    always #5 clk = ~clk;
    assign sif.SRAM_data_in = mem[sif.word_address_dest];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_fetch(input logic [6:0] r);
        fetch_row   = r;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    task automatic swap();
        buf_swap = 1'b1;
        tick();
        buf_swap = 1'b0;
    endtask

    task automatic read_pix(input logic [6:0] x, input logic exp, input string tag);
        pix_x = x;
        tick();
        check(tag, 32'(pixel_data), 32'(exp));
    endtask

    initial begin
        logic [6:0] p0 [5];
        logic       e0 [5];
        p0 = '{7'd0, 7'd31, 7'd32, 7'd63, 7'd96};
        e0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[0] = 32'h0000_0001; mem[1] = 32'h8000_0000; mem[3] = 32'hFFFF_FFFF;
        mem[4] = 32'h0000_0001;
        mem[11] = 32'h8000_0000;
        mem[380] = 32'h0000_0002; mem[383] = 32'h4000_0000;
        sif.SRAM_busy = 1'b0;

        // Reset state
        #12;
        check("rst_data_en", 32'(sif.data_en), 0);
        check("rst_bsel", 32'(sif.byte_select), 0);
        check("rst_busy", 32'(fetch_busy), 0);
        check("rst_done", 32'(fetch_done), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_pix", 32'(pixel_data), 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // Basic fetch of row 0
        start_fetch(7'd0);
        for (int k = 0; k < 4; k++) begin
            check("t1_addr", 32'(sif.word_address_dest), 32'(k));
            check("t1_en", 32'(sif.data_en), 1);
            check("t1_bsel", 32'(sif.byte_select), 32'hF);
            check("t1_done_early", 32'(fetch_done), 0);
            tick();
        end
        check("t1_done", 32'(fetch_done), 1);
        check("t1_en_off", 32'(sif.data_en), 0);
        tick();
        check("t1_done_pulse", 32'(fetch_done), 0);
        swap();
        for (int i = 0; i < 5; i++) read_pix(p0[i], e0[i], "t1_pix");

        // Busy stall on word 1 of row 95
        start_fetch(7'd95);
        check("t2_addr0", 32'(sif.word_address_dest), 380);
        tick();
        sif.SRAM_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t2_hold", 32'(sif.word_address_dest), 381);
            check("t2_hold_en", 32'(sif.data_en), 1);
            tick();
        end
        sif.SRAM_busy = 1'b0;
        check("t2_hold4", 32'(sif.word_address_dest), 381);
        tick();
        check("t2_addr2", 32'(sif.word_address_dest), 382);
        tick();
        check("t2_addr3", 32'(sif.word_address_dest), 383);
        check("t2_done_early", 32'(fetch_done), 0);
        tick();
        check("t2_done", 32'(fetch_done), 1);
        tick();
        swap();
        read_pix(7'd1, 1'b1, "t2_pix1");
        read_pix(7'd0, 1'b0, "t2_pix0");
        read_pix(7'd126, 1'b1, "t2_pix126");

        // Out-of-range row
        start_fetch(7'd100);
        check("t3_en", 32'(sif.data_en), 0);
        check("t3_busy", 32'(fetch_busy), 1);
        check("t3_done_early", 32'(fetch_done), 0);
        tick();
        check("t3_done", 32'(fetch_done), 1);
        check("t3_en2", 32'(sif.data_en), 0);
        tick();
        swap();
        for (int i = 0; i < 128; i++) read_pix(7'(i), 1'b0, "t3_zero");

        // Swap mid-fetch sets underrun and leaves front alone
        start_fetch(7'd1);
        tick();
        buf_swap = 1'b1;
        tick();
        buf_swap = 1'b0;
        check("t4_underrun", 32'(underrun), 1);
        check("t4_addr", 32'(sif.word_address_dest), 6);
        tick();
        tick();
        check("t4_done", 32'(fetch_done), 1);
        tick();
        read_pix(7'd0, 1'b0, "t4_front_kept");
        check("t4_sticky", 32'(underrun), 1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("t4_clr", 32'(underrun), 0);

        // Swap on the final accept
        start_fetch(7'd2);
        tick();
        tick();
        tick();
        check("t4b_addr3", 32'(sif.word_address_dest), 11);
        buf_swap = 1'b1;
        tick();
        buf_swap = 1'b0;
        check("t4b_done", 32'(fetch_done), 1);
        check("t4b_no_underrun", 32'(underrun), 0);
        read_pix(7'd127, 1'b1, "t4b_pix127");
        read_pix(7'd0, 1'b0, "t4b_pix0");
        check("t4b_underrun_end", 32'(underrun), 0);

        // fetch_start during REQ is ignored
        start_fetch(7'd3);
        check("t5_addr0", 32'(sif.word_address_dest), 12);
        fetch_row   = 7'd50;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check("t5_addr", 32'(sif.word_address_dest), 32'(12 + k));
            tick();
        end
        check("t5_done", 32'(fetch_done), 1);
        tick();
        check("t5_idle_en", 32'(sif.data_en), 0);

        // Asynchronous reset mid-fetch
        pix_x = 7'd127;
        start_fetch(7'd0);
        tick();
        tick();
        check("t5_pre_addr", 32'(sif.word_address_dest), 2);
        check("t5_pre_pix", 32'(pixel_data), 1);
        #2 nrst = 1'b0;
        #1;
        check("t5_rst_en", 32'(sif.data_en), 0);
        check("t5_rst_busy", 32'(fetch_busy), 0);
        check("t5_rst_pix", 32'(pixel_data), 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        start_fetch(7'd1);
        for (int k = 0; k < 4; k++) begin
            check("t5_row1_addr", 32'(sif.word_address_dest), 32'(4 + k));
            tick();
        end
        check("t5_row1_done", 32'(fetch_done), 1);
        tick();
        swap();
        read_pix(7'd0, 1'b1, "t5_row1_pix0");
        read_pix(7'd127, 1'b0, "t5_row1_pix127");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_fetch.md
Name: vga_fb_fetch

Overview:
- Upstream stage of VGA_out: prefetches one framebuffer row (128 px, 1 bpp, 4 × 32-bit words) from SRAM into a ping-pong line buffer. It then serves single pixel bits to the VGA output stage.
- Framebuffer is 128×96 1 bpp, 384 words at BASE_ADDR. The VGA timing side shows each row for 5 scanlines (640×480).
- The timing side requests the next row during blanking and swaps buffers at line start, so the active region never waits on SRAM_busy.

Parameters:
- WORDS_PER_ROW, 4, 32-bit words per framebuffer row.
- ROWS, 96, number of framebuffer rows.
- ADDR_W, 9, SRAM word address width.
- BASE_ADDR, 0, word address of row 0, word 0.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- nrst  in  1  asynchronous active-low reset.
- fetch_start  in  1  one-cycle pulse: load row fetch_row into back buffer.
- fetch_row  in  7  framebuffer row index, sampled on fetch_start.
- buf_swap  in  1  one-cycle pulse: exchange front/back buffers.
- underrun_clr  in  1  clears the underrun flag.
- SRAM_busy  in  1  high = request not accepted this cycle.
- SRAM_data_in  in  32  read data, valid in the accept cycle.
- data_en  out  1  SRAM read request.
- word_address_dest  out  ADDR_W  SRAM word address.
- byte_select  out  4  byte enables; 4'b1111 while data_en=1, else 0.
- pix_x  in  7  pixel column 0..127 to read from the front buffer.
- pixel_data  out  1  front-buffer bit for pix_x, registered.
- fetch_busy  out  1  high while state is REQ or ZERO.
- fetch_done  out  1  one-cycle pulse when the back buffer is complete.
- underrun  out  1  sticky: buf_swap arrived while a fetch was in progress.

Behaviour:
- Reset (nrst=0, async): all outputs 0, state IDLE, word_idx=0, front select=0, both buffers cleared to 0. Reset mid-fetch aborts the fetch; no partial data is kept.
- FSM states: IDLE, REQ, ZERO, DONE.
- IDLE:
  - fetch_start=1 latches row=fetch_row and sets word_idx=0.
  - If row<ROWS, go to REQ; otherwise go to ZERO.
- REQ:
  - data_en=1, byte_select=4'b1111.
  - word_address_dest = (BASE_ADDR + row*WORDS_PER_ROW + word_idx), truncated to ADDR_W bits.
  - Address and data_en are held stable while SRAM_busy=1.
  - Accept cycle = data_en=1 and SRAM_busy=0. On that posedge, SRAM_data_in is written to back[word_idx].
  - After an accept: if word_idx==WORDS_PER_ROW-1, go to DONE; else word_idx+1.
  - data_en stays 1 across consecutive words (back-to-back accepts allowed, 1 word per cycle max).
- ZERO (row out of range): no SRAM access. Clear all back words in one cycle, then go to DONE.
- DONE: fetch_done=1 for exactly one cycle, data_en=0, then go to IDLE.
- fetch_start while not IDLE is ignored (no restart, no flag).
- Fetch latency: WORDS_PER_ROW accept cycles + 1 cycle (DONE). Minimum 5 cycles from the fetch_start edge to the fetch_done pulse.
- buf_swap:
  - In IDLE or DONE: front select toggles at that edge.
  - In REQ or ZERO: swap is ignored, underrun←1.
  - Exception: buf_swap in the same cycle as the final REQ accept. The word is written into the back buffer and the swap is performed at that same edge, so the new row becomes front. No underrun.
- underrun: sticky; cleared only by underrun_clr or reset. Set has priority over clear in the same cycle.
- pixel_data: registered, 1-cycle latency. Value is front[pix_x[6:5]][pix_x[4:0]]; bit 0 of each word is the leftmost pixel.
  - pixel_data reflects a swap starting the cycle after the swap edge.
  - pixel_data never reads the back buffer.
- fetch_busy=1 in REQ and ZERO; fetch_busy=0 in IDLE and DONE.

Test Plan:
1. Reset/basic fetch:
   - Stimulus: reset; fetch_start with row=0; SRAM_busy=0; memory[0..3]=32'h0000_0001, 32'h8000_0000, 0, 32'hFFFF_FFFF.
   - Required: addresses 0,1,2,3 on 4 consecutive cycles, data_en high 4 cycles, fetch_done pulse on the 5th cycle.
   - Then buf_swap, then pix_x=0,31,32,63,96. Required pixel_data = 1,0,0,1,1, each one cycle after pix_x.
2. Busy stall:
   - Stimulus: fetch row 95 with SRAM_busy held high for 3 cycles on word 1.
   - Required: word_address_dest holds 381 for 4 cycles; addresses sequence 380..383; fetch_done exactly 1 cycle after the 383 accept.
3. Out-of-range row:
   - Stimulus: fetch row 100.
   - Required: data_en never asserts, fetch_done asserts 2 cycles after fetch_start; after swap, pixel_data=0 for all 128 columns.
4. Underrun and simultaneity:
   - Stimulus: buf_swap mid-fetch.
   - Required: underrun=1, front unchanged. Pulse underrun_clr, then underrun=0.
   - Stimulus: buf_swap on the final accept cycle.
   - Required: new row visible, underrun stays 0.
5. Ignored start / reset mid-fetch:
   - Stimulus: fetch_start during REQ.
   - Required: address sequence is unaffected.
   - Stimulus: assert nrst=0 while word_address_dest=2 (async, between edges).
   - Required: data_en, fetch_busy, and pixel_data drop to 0 immediately; a following fetch of row 1 issues addresses 4..7.
